// File: rtl/midi_note_tx.sv
// midi_note_tx: queued MIDI Note On/Off serialiser on a 31250-baud UART line.
// Define MIDI_TX_RUNNING_STATUS_EN to drop repeated status bytes.
module midi_note_tx #(
  parameter int         CLK_HZ     = 50000000,
  parameter int         BAUD       = 31250,
  parameter logic [3:0] CHANNEL    = 4'd0,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       note_on,
  input  logic       note_off,
  input  logic [6:0] note,
  input  logic [6:0] velocity,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DIV - 1);
  localparam logic [AW:0]   FULL = (AW+1)'(FIFO_DEPTH);

  localparam logic [7:0] ST_ON = {4'h9, CHANNEL};
`ifdef MIDI_TX_RUNNING_STATUS_EN
  localparam bit         RS_EN   = 1'b1;
  localparam logic [7:0] ST_OFF  = {4'h9, CHANNEL};
  localparam logic [6:0] OFF_VEL = 7'h00;
`else
  localparam bit         RS_EN   = 1'b0;
  localparam logic [7:0] ST_OFF  = {4'h8, CHANNEL};
  localparam logic [6:0] OFF_VEL = 7'h40;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // Entry layout: {is_note_on, note, third_byte}
  logic [14:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_overflow;

  logic        w_strobe;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic [14:0] w_head;
  logic [7:0]  w_head_st;
  logic        w_skip;

  assign w_strobe  = note_on | note_off;
  assign w_full    = (r_count == FULL);
  assign w_empty   = (r_count == '0);
  assign w_push    = w_strobe & ~w_full;
  assign w_head    = r_mem[r_rptr];
  assign w_head_st = w_head[14] ? ST_ON : ST_OFF;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {note_on, note, note_on ? velocity : OFF_VEL};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count    <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_overflow <= w_strobe & w_full;
    end
  end

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [1:0]    r_idx;
  logic [7:0]    r_shift;
  logic [6:0]    r_note;
  logic [6:0]    r_d2;
  logic [7:0]    r_last;

  state_t        w_state_n;
  logic [CW-1:0] w_cnt_n;
  logic [2:0]    w_bit_n;
  logic [1:0]    w_idx_n;
  logic [7:0]    w_shift_n;
  logic [6:0]    w_note_n;
  logic [6:0]    w_d2_n;
  logic [7:0]    w_last_n;
  logic          w_tick;
  logic          w_load;

  assign w_tick = (r_cnt == CMAX);
  assign w_skip = RS_EN && (w_head_st == r_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_idx   <= '0;
      r_shift <= 8'hFF;
      r_note  <= '0;
      r_d2    <= '0;
      r_last  <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_bit   <= w_bit_n;
      r_idx   <= w_idx_n;
      r_shift <= w_shift_n;
      r_note  <= w_note_n;
      r_d2    <= w_d2_n;
      r_last  <= w_last_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_bit_n   = r_bit;
    w_idx_n   = r_idx;
    w_shift_n = r_shift;
    w_note_n  = r_note;
    w_d2_n    = r_d2;
    w_last_n  = r_last;
    w_load    = 1'b0;
    w_pop     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_load = ~w_empty;
      end
      S_START: begin
        w_cnt_n = r_cnt + 1'b1;
        if (w_tick) begin
          w_cnt_n   = '0;
          w_bit_n   = '0;
          w_state_n = S_DATA;
        end
      end
      S_DATA: begin
        w_cnt_n = r_cnt + 1'b1;
        if (w_tick) begin
          w_cnt_n   = '0;
          w_shift_n = {1'b1, r_shift[7:1]};
          w_bit_n   = r_bit + 1'b1;
          if (r_bit == 3'd7) w_state_n = S_STOP;
        end
      end
      S_STOP: begin
        w_cnt_n = r_cnt + 1'b1;
        if (w_tick) begin
          w_cnt_n = '0;
          if (r_idx != 2'd2) begin
            w_idx_n   = r_idx + 1'b1;
            w_shift_n = (r_idx == 2'd0) ? {1'b0, r_note} : {1'b0, r_d2};
            w_state_n = S_START;
          end else if (!w_empty) begin
            w_load = 1'b1;
          end else begin
            w_state_n = S_IDLE;
          end
        end
      end
    endcase
    // Pop path shared by IDLE and the end of a message's last stop bit
    if (w_load) begin
      w_pop     = 1'b1;
      w_note_n  = w_head[13:7];
      w_d2_n    = w_head[6:0];
      w_last_n  = w_head_st;
      w_cnt_n   = '0;
      w_state_n = S_START;
      w_idx_n   = w_skip ? 2'd1 : 2'd0;
      w_shift_n = w_skip ? {1'b0, w_head[13:7]} : w_head_st;
    end
  end

  always_comb begin
    tx = 1'b1;
    unique case (r_state)
      S_START: tx = 1'b0;
      S_DATA:  tx = r_shift[0];
      S_IDLE:  tx = 1'b1;
      S_STOP:  tx = 1'b1;
    endcase
  end

  assign busy     = (r_state != S_IDLE) | ~w_empty;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_midi_note_tx.sv
// tb_midi_note_tx: directed and random note bursts decoded off the tx line
// and compared against a byte-level MIDI message model.
module tb_midi_note_tx;

  localparam int CLK_HZ   = 312500;
  localparam int BAUD     = 31250;
  localparam int DIV      = CLK_HZ / BAUD;
  localparam int BYTE_CYC = 10 * DIV;
  localparam int FD       = 4;
  localparam logic [3:0] CH = 4'd0;
`ifdef MIDI_TX_RUNNING_STATUS_EN
  localparam bit RS = 1'b1;
`else
  localparam bit RS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       note_on;
  logic       note_off;
  logic [6:0] note;
  logic [6:0] velocity;
  logic       tx;
  logic       busy;
  logic       overflow;

  always #5 clk = ~clk;

  midi_note_tx #(
    .CLK_HZ(CLK_HZ),
    .BAUD(BAUD),
    .CHANNEL(CH),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .note_on(note_on),
    .note_off(note_off),
    .note(note),
    .velocity(velocity),
    .tx(tx),
    .busy(busy),
    .overflow(overflow)
  );

  int n_err    = 0;
  int n_checks = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // UART receiver: samples mid-bit, relative to the first low sample
  int         cyc = 0;
  bit         m_act = 1'b0;
  int         m_t;
  int         m_start;
  logic [7:0] m_sh;
  logic [7:0] rx_q[$];
  int         rx_t[$];
  int         stop_bad = 0;
  int         ovf_seen = 0;

  always @(negedge clk) begin
    cyc++;
    if (overflow === 1'b1) ovf_seen++;
    if (rst !== 1'b0) begin
      m_act = 1'b0;
    end else if (!m_act) begin
      if (tx === 1'b0) begin
        m_act   = 1'b1;
        m_t     = 0;
        m_start = cyc;
      end
    end else begin
      m_t++;
      if (m_t % DIV == DIV / 2) begin
        if (m_t / DIV == 0) begin
          if (tx !== 1'b0) stop_bad++;
        end else if (m_t / DIV <= 8) begin
          m_sh[m_t / DIV - 1] = tx;
        end else begin
          if (tx !== 1'b1) stop_bad++;
          rx_q.push_back(m_sh);
          rx_t.push_back(m_start);
          m_act = 1'b0;
        end
      end
    end
  end

  // Message model
  logic [7:0] exp_q[$];
  logic [7:0] m_last = 8'h00;

  task automatic model_event(input bit on, input logic [6:0] n,
                             input logic [6:0] v);
    logic [7:0] st;
    logic [7:0] d2;
    st = (on || RS) ? (8'h90 | {4'h0, CH}) : (8'h80 | {4'h0, CH});
    d2 = on ? {1'b0, v} : (RS ? 8'h00 : 8'h40);
    if (!(RS && st == m_last)) exp_q.push_back(st);
    m_last = st;
    exp_q.push_back({1'b0, n});
    exp_q.push_back(d2);
  endtask

  bit         e_on [8];
  bit         e_off[8];
  logic [6:0] e_note[8];
  logic [6:0] e_vel [8];

  task automatic set_ev(input int i, input bit on, input bit off,
                        input logic [6:0] n, input logic [6:0] v);
    e_on[i]   = on;
    e_off[i]  = off;
    e_note[i] = n;
    e_vel[i]  = v;
  endtask

  // Strobes k events on consecutive cycles from idle; rst_at >= 0 resets
  task automatic run_burst(input string tag, input int k, input int rst_at);
    int span;
    int ovf0;
    int last_j;
    int ovf_exp;
    for (int i = 0; i < k; i++)
      if (i <= FD) model_event(e_on[i], e_note[i], e_vel[i]);
    span    = exp_q.size() * BYTE_CYC;
    ovf0    = ovf_seen;
    ovf_exp = (rst_at < 0 && k > FD + 1) ? k - FD - 1 : 0;
    last_j  = (rst_at >= 0) ? rst_at + 3 : span + 2;
    for (int j = 0; j <= last_j; j++) begin
      @(negedge clk);
      if (j < k) begin
        note_on  = e_on[j];
        note_off = e_off[j];
        note     = e_note[j];
        velocity = e_vel[j];
      end else begin
        note_on  = 1'b0;
        note_off = 1'b0;
        note     = '0;
        velocity = '0;
      end
      if (rst_at >= 0 && j == rst_at)     rst = 1'b1;
      if (rst_at >= 0 && j == rst_at + 2) rst = 1'b0;
      if (j == 1) check({tag, "_tx_before_pop"}, tx, 1);
      if (j == 2) check({tag, "_start_latency"}, tx, 0);
      if (rst_at < 0 && j == span + 1) check({tag, "_busy_last"}, busy, 1);
      if (rst_at < 0 && j == span + 2) check({tag, "_busy_fall"}, busy, 0);
      if (rst_at >= 0 && j == rst_at + 1) begin
        check({tag, "_rst_tx"}, tx, 1);
        check({tag, "_rst_busy"}, busy, 0);
        check({tag, "_rst_ovf"}, overflow, 0);
      end
    end
    if (rst_at >= 0) begin
      while (exp_q.size() > 1) void'(exp_q.pop_back());
      m_last = 8'h00;
    end
    repeat (3 * BYTE_CYC) @(negedge clk);
    check({tag, "_ovf_pulses"}, ovf_seen - ovf0, ovf_exp);
    check({tag, "_nbytes"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
      if (i > 0)
        check($sformatf("%s_gap%0d", tag, i), rx_t[i] - rx_t[i-1], BYTE_CYC);
    end
    check({tag, "_framing"}, stop_bad, 0);
    rx_q.delete();
    rx_t.delete();
    exp_q.delete();
    stop_bad = 0;
  endtask

  initial begin
    int k;
    int ty;
    rst      = 1'b1;
    note_on  = 1'b0;
    note_off = 1'b0;
    note     = '0;
    velocity = '0;
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_ovf", overflow, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_tx", tx, 1);

    set_ev(0, 1'b1, 1'b0, 7'd60, 7'd100);
    run_burst("note_on", 1, -1);

    set_ev(0, 1'b0, 1'b1, 7'd60, 7'd0);
    run_burst("note_off", 1, -1);

    set_ev(0, 1'b1, 1'b1, 7'd64, 7'd10);
    run_burst("both", 1, -1);

    set_ev(0, 1'b1, 1'b0, 7'd60, 7'd100);
    set_ev(1, 1'b0, 1'b1, 7'd62, 7'd0);
    run_burst("b2b", 2, -1);

    for (int i = 0; i < 6; i++)
      set_ev(i, 1'b1, 1'b0, 7'(40 + i), 7'(90 + i));
    run_burst("overflow", 6, -1);

    set_ev(0, 1'b1, 1'b0, 7'd72, 7'd55);
    run_burst("reset_mid", 1, 2 + BYTE_CYC + 4 * DIV);

    set_ev(0, 1'b1, 1'b0, 7'd61, 7'd33);
    run_burst("after_rst", 1, -1);

    for (int r = 0; r < 10; r++) begin
      k = $urandom_range(1, 7);
      for (int i = 0; i < k; i++) begin
        ty = $urandom_range(0, 2);
        set_ev(i, ty != 1, ty != 0, 7'($urandom_range(0, 127)),
               7'($urandom_range(0, 127)));
      end
      run_burst($sformatf("rand%0d", r), k, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
